// File: rtl/reload_down_counter_pkg.sv
// Shared types for the reload down-counter: counting modes and FSM states.
package reload_down_counter_pkg;

   // Encoding 2'b11 is reserved and treated as DC_WRAP.
   typedef enum logic [1:0] {
      DC_WRAP    = 2'd0,
      DC_RELOAD  = 2'd1,
      DC_ONESHOT = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/reload_down_counter_if.sv
// Control and status bundle of the reload down-counter.
interface reload_down_counter_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned PW    = 2
);
   logic             ld;
   logic [WIDTH-1:0] PI;
   logic             en;
   logic [1:0]       mode;
   logic [PW-1:0]    presc;
   logic [WIDTH-1:0] C;
   logic             bout;
   logic             zero;
   logic             busy;

   modport master (
      output ld, PI, en, mode, presc,
      input  C, bout, zero, busy
   );

   modport slave (
      input  ld, PI, en, mode, presc,
      output C, bout, zero, busy
   );
endinterface

// File: rtl/reload_down_counter_prescaler.sv
// Enable-gated prescaler: one tick every presc+1 enabled cycles, cleared by clr.
module reload_down_counter_prescaler #(
   parameter int unsigned PW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [PW-1:0] presc,
   output logic          tick
);

   logic [PW-1:0] pcnt_q, pcnt_d;

   // >= rather than == so lowering presc past pcnt still ticks at once.
   always_comb begin
      tick   = 1'b0;
      pcnt_d = pcnt_q;
      if (clr) begin
         pcnt_d = '0;
      end else if (en) begin
         if (pcnt_q >= presc) begin
            tick   = 1'b1;
            pcnt_d = '0;
         end else begin
            pcnt_d = pcnt_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule

// File: rtl/reload_down_counter.sv
// Loadable prescaled down-counter with borrow pulse and wrap/reload/one-shot modes.
module reload_down_counter
   import reload_down_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned PW    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   reload_down_counter_if.slave  bus
);

   logic [WIDTH-1:0] c_q, c_d;
   logic [WIDTH-1:0] rl_q, rl_d;
   logic             bout_q, bout_d;
   state_e           state_q, state_d;
   logic             tick;

   reload_down_counter_prescaler #(
      .PW(PW)
   ) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.ld),
      .en    (bus.en),
      .presc (bus.presc),
      .tick  (tick)
   );

   always_comb begin
      c_d     = c_q;
      rl_d    = rl_q;
      bout_d  = 1'b0;
      state_d = state_q;
      if (bus.ld) begin
         c_d     = bus.PI;
         rl_d    = bus.PI;
         state_d = S_RUN;
      end else if (tick && (state_q == S_RUN)) begin
         if (c_q != '0) begin
            c_d = c_q - WIDTH'(1);
         end else begin
            // Borrow out of zero; mode is sampled only here.
            bout_d = 1'b1;
            case (mode_e'(bus.mode))
               DC_RELOAD:  c_d     = rl_q;
               DC_ONESHOT: state_d = S_DONE;
               default:    c_d     = '1;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_q     <= '0;
         rl_q    <= '0;
         bout_q  <= 1'b0;
         state_q <= S_IDLE;
      end else begin
         c_q     <= c_d;
         rl_q    <= rl_d;
         bout_q  <= bout_d;
         state_q <= state_d;
      end
   end

   assign bus.C    = c_q;
   assign bus.bout = bout_q;
   assign bus.zero = (c_q == '0);
   assign bus.busy = (state_q == S_RUN);

endmodule

// File: tb/tb_reload_down_counter.sv
// Directed table-driven bench for reload_down_counter with a few hand-written corner sequences.
module tb_reload_down_counter;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   reload_down_counter_if #(.WIDTH(4), .PW(2)) bus ();

   reload_down_counter #(.WIDTH(4), .PW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic [3:0] pi;
      logic       en;
      logic [1:0] mode;
      logic [1:0] presc;
      logic [3:0] exp_c;
      logic       exp_bout;
      logic       exp_busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ld, logic [3:0] pi, logic en, logic [1:0] mode,
                               logic [1:0] presc, logic [3:0] c, logic bo, logic busy);
      vec_t v;
      v.ld = ld; v.pi = pi; v.en = en; v.mode = mode; v.presc = presc;
      v.exp_c = c; v.exp_bout = bo; v.exp_busy = busy;
      return v;
   endfunction

   task automatic check(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(string tag, logic [3:0] c, logic bo, logic busy);
      check({tag, " C"}, int'(bus.C), int'(c));
      check({tag, " bout"}, int'(bus.bout), int'(bo));
      check({tag, " busy"}, int'(bus.busy), int'(busy));
      check({tag, " zero"}, int'(bus.zero), int'(c == 4'd0));
   endtask

   // Drive one vector, clock it in, sample 1ns after the edge.
   task automatic apply(string tag, vec_t v);
      bus.ld = v.ld; bus.PI = v.pi; bus.en = v.en; bus.mode = v.mode; bus.presc = v.presc;
      @(posedge clk);
      #1;
      check_outs(tag, v.exp_c, v.exp_bout, v.exp_busy);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      bus.ld = 1'b0; bus.PI = '0; bus.en = 1'b0; bus.mode = 2'd0; bus.presc = '0;

      // Reset, then enabled but idle for 20 cycles.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 4'h0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) apply($sformatf("idle%0d", i), mk(0, 0, 1, 0, 0, 0, 0, 0));

      // WRAP, presc=0, PI=3
      vecs.push_back(mk(1, 3, 0, 0, 0, 4'h3, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 4'h2, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 4'h1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 4'h0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 4'hF, 1, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 4'hE, 0, 1));
      // RELOAD, presc=2, PI=2: one step every 3 cycles, borrow every 9
      vecs.push_back(mk(1, 2, 1, 1, 2, 4'h2, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 4'h2, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 4'h2, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 4'h1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 4'h1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 4'h1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 4'h0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 4'h0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 4'h0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 4'h2, 1, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 4'h2, 0, 1));
      // en low freezes count and prescaler phase
      vecs.push_back(mk(0, 0, 0, 1, 2, 4'h2, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 2, 4'h2, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 4'h2, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 4'h1, 0, 1));
      // ONESHOT, presc=0, PI=1
      vecs.push_back(mk(1, 1, 1, 2, 0, 4'h1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 2, 0, 4'h0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 2, 0, 4'h0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 2, 0, 4'h0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 2, 0, 4'h0, 0, 0));
      vecs.push_back(mk(1, 5, 1, 2, 0, 4'h5, 0, 1));
      // ld with en at C=7: no decrement, prescaler cleared
      vecs.push_back(mk(1, 7, 1, 0, 1, 4'h7, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 1, 4'h7, 0, 1));
      vecs.push_back(mk(1, 9, 1, 0, 1, 4'h9, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 1, 4'h9, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 1, 4'h8, 0, 1));
      // RELOAD with PI=0, presc=0: continuous borrow
      vecs.push_back(mk(1, 0, 1, 1, 0, 4'h0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 4'h0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 4'h0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 4'h0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 4'h0, 0, 1));

      foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i]);

      // Asynchronous reset mid-count at C=6, checked before the next edge.
      apply("arst_ld", mk(1, 6, 1, 0, 3, 4'h6, 0, 1));
      #2;
      rst = 1'b1;
      #1;
      check_outs("arst", 4'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Lower presc from 3 to 0 while pcnt=2: next enabled cycle ticks.
      apply("presc_ld", mk(1, 5, 1, 0, 3, 4'h5, 0, 1));
      apply("presc_p1", mk(0, 0, 1, 0, 3, 4'h5, 0, 1));
      apply("presc_p2", mk(0, 0, 1, 0, 3, 4'h5, 0, 1));
      apply("presc_low0", mk(0, 0, 1, 0, 0, 4'h4, 0, 1));
      apply("presc_low1", mk(0, 0, 1, 0, 0, 4'h3, 0, 1));

      // Reserved mode wraps like WRAP.
      apply("rsv_ld", mk(1, 0, 1, 3, 0, 4'h0, 0, 1));
      apply("rsv_wrap", mk(0, 0, 1, 3, 0, 4'hF, 1, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reload_down_counter.md
Name: reload_down_counter

Overview:
Loadable, prescaled down-counter. It is the count-down counterpart of the team's up-counter with load and carry-out.
- Counts from a loaded value to zero.
- Signals the borrow out of zero with a one-clock pulse.
- Then wraps, reloads or stops, according to the mode.
- Used as a programmable interval and one-shot timer beside the up-counters in the datapath controllers.

Parameters:
WIDTH, 4, count and load-value width
PW, 2, prescaler select width; division ratio is presc+1 (1..2^PW)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ld  in  1  synchronous load; priority over en
PI  in  WIDTH  parallel load / reload value
en  in  1  count enable, gates the prescaler
mode  in  2  0=WRAP, 1=RELOAD, 2=ONESHOT, 3=reserved (behaves as WRAP)
presc  in  PW  prescale select; one decrement per presc+1 enabled cycles
C  out  WIDTH  current count (registered)
bout  out  1  borrow pulse (registered)
zero  out  1  C==0 (combinational from C)
busy  out  1  high in state RUN

Behaviour:
- Reset (async, rst high):
  - C=0, bout=0, rl=0 (internal reload register), pcnt=0, state=IDLE.
  - Therefore zero=1 and busy=0.
- States:
  - IDLE: ticks ignored; ld -> RUN.
  - RUN: counting.
  - DONE: ONESHOT terminated; ticks ignored; ld -> RUN.
- Load: on ld at posedge, in any state:
  - C<=PI, rl<=PI, pcnt<=0, bout<=0, state<=RUN.
  - No decrement and no tick that cycle, even if en=1.
- Prescaler:
  - With en=1 and no ld: tick = (pcnt >= presc).
  - On tick, pcnt<=0; otherwise pcnt<=pcnt+1.
  - With en=0, pcnt holds and there is no tick.
  - Using >= means that lowering presc mid-run can never lock up the prescaler.
  - pcnt advances in every state, but ticks act only in RUN.
- Tick in RUN, C!=0: C<=C-1, bout<=0.
- Tick in RUN, C==0 (borrow): bout<=1 for the following cycle only.
  - WRAP/reserved: C<=all ones (4'hF at default).
  - RELOAD: C<=rl.
  - ONESHOT: C stays 0; state<=DONE.
- Any cycle without a borrow tick: bout<=0. bout is never high for two cycles unless borrows occur on consecutive ticks.
- Period: loading N gives N+1 ticks per borrow, so (N+1)*(presc+1) enabled cycles.
- Edge cases:
  - RELOAD with PI=0: borrow on every tick. With presc=0 and en=1, bout stays high continuously.
  - mode changes mid-run take effect at the next borrow. rl changes only via ld.
  - rst mid-count returns to the reset values immediately, independent of clk.
- Arithmetic: C-1 uses modulo 2^WIDTH truncation. pcnt is PW bits wide, so it never overflows because tick fires at presc.

Decomposition:
- Shared package: mode enum (DC_WRAP, DC_RELOAD, DC_ONESHOT) and state enum (S_IDLE, S_RUN, S_DONE).
- Sub-module prescaler (inputs clk, rst, clr=ld, en, presc; output tick) holds pcnt.
- The top level holds C, rl, bout and the FSM.

Test Plan:
1. Reset with en=1 and no ld -> C=0, zero=1, busy=0, bout never asserts over 20 cycles (IDLE ignores ticks).
2. WRAP, presc=0, ld PI=3, then en=1:
   - C goes 3,2,1,0,F,E on consecutive cycles.
   - bout=1 only in the cycle where C=F.
3. RELOAD, presc=2, ld PI=2, en=1:
   - C decrements every 3 cycles: 2,1,0,2.
   - bout pulses once every 9 cycles.
   - Drop en mid-period -> C and phase freeze; raise en -> counting resumes without losing phase.
4. ONESHOT, presc=0, ld PI=1:
   - C goes 1,0,0 and the state moves to DONE.
   - Exactly one bout pulse; busy falls with that pulse; C holds 0.
   - ld PI=5 -> busy=1, C=5.
5. ld and en together during RUN at C=7 with PI=9 -> next cycle C=9, no decrement, pcnt cleared. RELOAD with PI=0 and presc=0 -> bout stays high continuously.
6. Assert rst asynchronously mid-count at C=6 -> C=0 and busy=0 before the next clk edge. presc lowered from 3 to 0 while pcnt=2 -> tick on the next enabled cycle, no lockup.
